vend_arbiter: RTL
=================

// Module: vend_arbiter
// PURPOSE
//  Round-robin scheduler sharing one drink dispenser between NREQ customer panels.
//  Each panel presents a drink selection and its accumulated credit in 5$ units.
//  Arbiter grants one panel, checks credit against price, sequences the dispenser,
//  emits one change pulse per 5$ owed, then acks the panel.
//  Sits between the per-panel coin/sale front ends and the dispense mechanism.
// PARAMETERS
//  NREQ        2   number of requesting panels (2..8)
//  CW          4   credit width in 5$ units (max credit 2^CW-1)
//  TIMEOUT_CYC 64  dispense watchdog limit in cycles (used only with VEND_TIMEOUT_EN)
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        async active-low reset
//  req_valid   in   NREQ     per-panel request; held until that panel's ack
//  req_sel     in   NREQ     per-panel drink: 0 = 5$ drink (price 1), 1 = 10$ drink (price 2)
//  req_credit  in   NREQ*CW  per-panel credit, panel i at [i*CW +: CW]
//  grant       out  NREQ     one-hot owner, held from grant cycle through ack cycle
//  ack         out  1        1-cycle pulse: transaction for granted panel complete
//  ack_ok      out  1        valid with ack: 1 = drink vended, 0 = refused/refunded
//  disp_start  out  1        1-cycle pulse starting dispenser
//  disp_type   out  2        1 = 5$ drink, 2 = 10$ drink; stable while in DISP
//  disp_done   in   1        dispenser completion pulse
//  change_out  out  1        one 1-cycle pulse per 5$ unit returned
//  disp_fault  out  1        1-cycle pulse on dispense timeout (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE, grant=0, ack=0, ack_ok=0, disp_start=0, disp_type=0,
//   change_out=0, disp_fault=0, rr pointer=0. All outputs registered.
//  States: IDLE, CHECK, DISP, CHANGE, DONE.
//  IDLE: if any req_valid, pick first valid index searching upward from rr pointer
//   (wrap mod NREQ); register grant, latch sel and credit; -> CHECK. Else stay.
//  CHECK (1 cycle): price = sel?2:1. credit>=price: rem=credit-price, ok=1,
//   assert disp_start and disp_type for next cycle, -> DISP.
//   credit<price: rem=credit (full refund), ok=0; -> CHANGE if rem!=0 else DONE.
//  DISP: disp_start high first cycle only; wait disp_done.
//   On disp_done: -> CHANGE if rem!=0 else DONE. disp_type returns to 0 on exit.
//  CHANGE: change_out=1 each cycle, rem decrements; after last unit -> DONE.
//   Exactly rem pulses, back to back.
//  DONE (1 cycle): ack=1, ack_ok=ok; grant cleared on next cycle;
//   rr pointer = winner+1 mod NREQ; -> IDLE.
//  Latency: req_valid seen in IDLE at cycle 0 -> grant at 1 -> disp_start at 2.
//  Latched sel/credit used throughout; later changes to req_* ignored.
//  req_valid dropping while granted: transaction still completes and acks.
//  disp_done outside DISP ignored. Request in DONE cycle not sampled until IDLE.
//  Credit arithmetic unsigned CW bits; rem never underflows (checked in CHECK).
//  Reset mid-transaction: immediate return to IDLE, no ack, no further pulses.
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: cycle counter in DISP; if disp_done not seen within
//   TIMEOUT_CYC cycles of disp_start, pulse disp_fault, set ok=0, rem=full latched
//   credit (refund), -> CHANGE/DONE as above. disp_done same cycle as limit wins.
//  Not defined: no counter, DISP waits indefinitely, disp_fault constant 0.
// TESTING
//  Panel0 sel=0 credit=3, done 4 cycles after start -> disp_type=1, 2 change pulses, ack_ok=1.
//  Panel1 sel=1 credit=1 -> no disp_start, 1 change pulse, ack with ack_ok=0.
//  Both panels valid continuously, credit=2 sel=1 -> grants alternate 0,1,0,1; 0 change.
//  Reset asserted during CHANGE with rem=3 -> outputs 0 at once, no ack, restart in IDLE.
//  Unexpected disp_done pulsed in IDLE -> no state change, no output activity.
//  VEND_TIMEOUT_EN, TIMEOUT_CYC=8, credit=2 sel=0, no disp_done -> disp_fault, 2 pulses, ack_ok=0.

Source files
------------

// File: rtl/vend_arbiter.sv
// Round-robin arbiter sharing one drink dispenser between NREQ panels: credit check,
// dispense sequencing, change pulses and ack. Optional watchdog: define VEND_TIMEOUT_EN.
module vend_arbiter #(
    parameter int NREQ        = 2,
    parameter int CW          = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_sel,
    input  logic [NREQ*CW-1:0] req_credit,
    output logic [NREQ-1:0]    grant,
    output logic               ack,
    output logic               ack_ok,
    output logic               disp_start,
    output logic [1:0]         disp_type,
    input  logic               disp_done,
    output logic               change_out,
    output logic               disp_fault
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, CHECK, DISP, CHANGE, DONE} state_t;

    state_t            state, n_state;
    logic [NREQ-1:0]   n_grant;
    logic              n_ack, n_ack_ok, n_disp_start, n_change, n_fault;
    logic [1:0]        n_disp_type;
    logic [PW-1:0]     rr, n_rr, win, n_win, pick;
    logic              sel, n_sel, ok, n_ok, found;
    logic [CW-1:0]     credit, n_credit, rem, n_rem, price;
    logic [TW-1:0]     cnt, n_cnt;

    // First valid panel at or above the rr pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign price = sel ? CW'(2) : CW'(1);

    always_comb begin
        n_state      = state;
        n_grant      = grant;
        n_disp_start = 1'b0;
        n_disp_type  = disp_type;
        n_fault      = 1'b0;
        n_rr         = rr;
        n_win        = win;
        n_sel        = sel;
        n_credit     = credit;
        n_rem        = rem;
        n_ok         = ok;
        n_cnt        = cnt;
        case (state)
            IDLE: if (found) begin
                n_grant  = NREQ'(1) << pick;
                n_win    = pick;
                n_sel    = req_sel[pick];
                n_credit = req_credit[int'(pick)*CW +: CW];
                n_state  = CHECK;
            end
            CHECK: if (credit >= price) begin
                n_rem        = credit - price;
                n_ok         = 1'b1;
                n_disp_start = 1'b1;
                n_disp_type  = sel ? 2'd2 : 2'd1;
                n_cnt        = '0;
                n_state      = DISP;
            end else begin
                n_rem   = credit;
                n_ok    = 1'b0;
                n_state = (credit != '0) ? CHANGE : DONE;
            end
            DISP: begin
                if (disp_done)
                    n_state = (rem != '0) ? CHANGE : DONE;
`ifdef VEND_TIMEOUT_EN
                else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
                    // Watchdog expired: refund everything the customer put in.
                    n_fault = 1'b1;
                    n_ok    = 1'b0;
                    n_rem   = credit;
                    n_state = (credit != '0) ? CHANGE : DONE;
                end
`endif
                else
                    n_cnt = cnt + TW'(1);
            end
            CHANGE: begin
                n_rem = rem - CW'(1);
                if (rem == CW'(1))
                    n_state = DONE;
            end
            DONE: begin
                n_rr    = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
                n_state = IDLE;
            end
            default: n_state = IDLE;
        endcase
        // Registered outputs follow the state being entered.
        if (n_state == IDLE) n_grant = '0;
        if (n_state != DISP) n_disp_type = 2'd0;
        n_change = (n_state == CHANGE);
        n_ack    = (n_state == DONE);
        n_ack_ok = (n_state == DONE) && n_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            ack        <= 1'b0;
            ack_ok     <= 1'b0;
            disp_start <= 1'b0;
            disp_type  <= 2'd0;
            change_out <= 1'b0;
            disp_fault <= 1'b0;
            rr         <= '0;
            win        <= '0;
            sel        <= 1'b0;
            credit     <= '0;
            rem        <= '0;
            ok         <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= n_state;
            grant      <= n_grant;
            ack        <= n_ack;
            ack_ok     <= n_ack_ok;
            disp_start <= n_disp_start;
            disp_type  <= n_disp_type;
            change_out <= n_change;
            disp_fault <= n_fault;
            rr         <= n_rr;
            win        <= n_win;
            sel        <= n_sel;
            credit     <= n_credit;
            rem        <= n_rem;
            ok         <= n_ok;
            cnt        <= n_cnt;
        end
    end
endmodule
